// File: rtl/lab2_out_monitor.sv
// lab2_out_monitor: synchronizes the gate-network output, strobes its edges,
// and measures high-pulse widths, pulse counts and short-pulse (glitch) counts.
module lab2_out_monitor #(
    parameter int CNT_W     = 8,
    parameter int WID_W     = 8,
    parameter int MIN_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             en,
    input  logic             clear,
    output logic             sig_sync,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] pulse_count,
    output logic [CNT_W-1:0] glitch_count,
    output logic             glitch_flag,
    output logic [WID_W-1:0] last_width,
    output logic             width_valid
);

    typedef enum logic [1:0] {WAIT_LOW, IDLE, MEAS} state_t;

    localparam logic [WID_W-1:0] WID_MAX = {WID_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WID_W-1:0] MIN_W   = WID_W'(MIN_WIDTH);

    logic             s1, s2, s3;
    logic [1:0]       fill;
    state_t           state, state_nxt;
    logic             done;
    logic [WID_W-1:0] wcnt;

    // Two-flop synchronizer plus a history flop for edge detection. The fill
    // shifter marks when s2 holds a real sample rather than its reset zero, so
    // a level already high at reset release is not mistaken for a fresh rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            fill <= 2'b00;
        end else begin
            s1   <= sig_in;
            s2   <= s1;
            s3   <= s2;
            fill <= {fill[0], 1'b1};
        end
    end

    assign sig_sync   = s2;
    assign rise_pulse = s2 & ~s3;
    assign fall_pulse = ~s2 & s3;

    // Measurement FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_LOW;
        else        state <= state_nxt;
    end

    // Next state; clear and a dropped enable both force a re-arm through WAIT_LOW.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        if (clear || !en) begin
            state_nxt = WAIT_LOW;
        end else begin
            case (state)
                WAIT_LOW: if (fill[1] && !s2) state_nxt = IDLE;
                IDLE:     if (rise_pulse)     state_nxt = MEAS;
                MEAS: begin
                    if (fall_pulse) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default:  state_nxt = WAIT_LOW;
            endcase
        end
    end

    // Width counter and result registers; all counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt         <= '0;
            pulse_count  <= '0;
            glitch_count <= '0;
            glitch_flag  <= 1'b0;
            last_width   <= '0;
            width_valid  <= 1'b0;
        end else if (clear) begin
            wcnt         <= '0;
            pulse_count  <= '0;
            glitch_count <= '0;
            glitch_flag  <= 1'b0;
            last_width   <= '0;
            width_valid  <= 1'b0;
        end else begin
            width_valid <= 1'b0;
            if (state == IDLE && state_nxt == MEAS)
                wcnt <= {{(WID_W-1){1'b0}}, 1'b1};
            else if (state == MEAS && s2 && en && wcnt != WID_MAX)
                wcnt <= wcnt + 1'b1;
            if (done) begin
                last_width  <= wcnt;
                width_valid <= 1'b1;
                if (pulse_count != CNT_MAX)
                    pulse_count <= pulse_count + 1'b1;
                if (wcnt < MIN_W) begin
                    glitch_flag <= 1'b1;
                    if (glitch_count != CNT_MAX)
                        glitch_count <= glitch_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab2_out_monitor.sv
// Bench for lab2_out_monitor: a full-width instance and a narrow instance
// (CNT_W=2, WID_W=4) share one stimulus stream and one pulse-level model.
module tb_lab2_out_monitor;

    localparam int MINW = 2;

    logic clk = 1'b0;
    logic rst_n, sig_in, en, clear;
    always #5 clk = ~clk;

    logic       a_sync, a_rise, a_fall, a_gf, a_wv;
    logic [7:0] a_pc, a_gc, a_lw;
    logic       b_sync, b_rise, b_fall, b_gf, b_wv;
    logic [1:0] b_pc, b_gc;
    logic [3:0] b_lw;

    lab2_out_monitor #(.CNT_W(8), .WID_W(8), .MIN_WIDTH(MINW)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .clear(clear),
        .sig_sync(a_sync), .rise_pulse(a_rise), .fall_pulse(a_fall),
        .pulse_count(a_pc), .glitch_count(a_gc), .glitch_flag(a_gf),
        .last_width(a_lw), .width_valid(a_wv));

    lab2_out_monitor #(.CNT_W(2), .WID_W(4), .MIN_WIDTH(MINW)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .clear(clear),
        .sig_sync(b_sync), .rise_pulse(b_rise), .fall_pulse(b_fall),
        .pulse_count(b_pc), .glitch_count(b_gc), .glitch_flag(b_gf),
        .last_width(b_lw), .width_valid(b_wv));

    logic [31:0] stat_a, stat_b;
    assign stat_a = {3'b000, a_pc, a_gc, a_gf, a_lw, a_wv, a_sync, a_rise, a_fall};
    assign stat_b = {19'b0, b_pc, b_gc, b_gf, b_lw, b_wv, b_sync, b_rise, b_fall};

    // Model: edge index since reset release, raw samples, and per-edge history.
    int c;
    bit samp [0:16383];
    bit sy   [0:16383];
    bit ok   [0:16383];
    int m_pc_a, m_gc_a, m_lw_a, m_pc_b, m_gc_b, m_lw_b;
    bit m_gf, m_wv;
    int checks = 0;
    int errs   = 0;

    function automatic void model_reset();
        c = 0;
        m_pc_a = 0; m_gc_a = 0; m_lw_a = 0;
        m_pc_b = 0; m_gc_b = 0; m_lw_b = 0;
        m_gf = 0; m_wv = 0;
    endfunction

    // A pulse counts iff en=1 and clear=0 on every edge from the one before its
    // synchronized rise through its fall, and that earlier edge saw a real sample.
    task automatic model_edge(input bit s, input bit e, input bit cl);
        int r, w;
        bit good;
        c++;
        samp[c] = s;
        sy[c]   = (c >= 3) ? samp[c-2] : 1'b0;
        ok[c]   = e && !cl;
        m_wv    = 0;
        if (cl) begin
            m_pc_a = 0; m_gc_a = 0; m_lw_a = 0;
            m_pc_b = 0; m_gc_b = 0; m_lw_b = 0;
            m_gf = 0;
        end else if (c >= 2 && !sy[c] && sy[c-1]) begin
            r = c - 1;
            while (r > 1 && sy[r-1]) r--;
            good = (r - 1 >= 3);
            for (int k = r - 1; k <= c; k++) good = good && ok[k];
            if (good) begin
                w      = c - r;
                m_lw_a = (w > 255) ? 255 : w;
                m_lw_b = (w > 15) ? 15 : w;
                m_wv   = 1;
                if (m_pc_a < 255) m_pc_a++;
                if (m_pc_b < 3)   m_pc_b++;
                if (w < MINW) begin
                    m_gf = 1;
                    if (m_gc_a < 255) m_gc_a++;
                    if (m_gc_b < 3)   m_gc_b++;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_a();
        logic so, sp;
        so = (c >= 2) ? samp[c-1] : 1'b0;
        sp = (c >= 3) ? samp[c-2] : 1'b0;
        return {3'b000, 8'(m_pc_a), 8'(m_gc_a), m_gf, 8'(m_lw_a), m_wv, so, so & ~sp, ~so & sp};
    endfunction

    function automatic logic [31:0] exp_b();
        logic so, sp;
        so = (c >= 2) ? samp[c-1] : 1'b0;
        sp = (c >= 3) ? samp[c-2] : 1'b0;
        return {19'b0, 2'(m_pc_b), 2'(m_gc_b), m_gf, 4'(m_lw_b), m_wv, so, so & ~sp, ~so & sp};
    endfunction

    // One clock: drive at the negedge, model the posedge, return at the next negedge.
    task automatic cyc(input bit s, input bit e, input bit cl);
        sig_in = s; en = e; clear = cl;
        @(posedge clk);
        if (rst_n) model_edge(s, e, cl);
        @(negedge clk);
    endtask

    task automatic pulse(input int w, input int gap);
        repeat (w)   cyc(1'b1, 1'b1, 1'b0);
        repeat (gap) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        int wv_cnt;
        rst_n = 1'b0; sig_in = 1'b1; en = 1'b1; clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (stat_a !== 32'd0) begin errs++; $display("FAIL reset_a: got %h want 0", stat_a); end
        checks++; if (stat_b !== 32'd0) begin errs++; $display("FAIL reset_b: got %h want 0", stat_b); end
        rst_n = 1'b1;
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        wv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(i < 4, 1'b1, 1'b0);
            wv_cnt += a_wv;
        end
        checks++; if (a_pc !== 8'd1) begin errs++; $display("FAIL reset_pc: got %0d want 1", a_pc); end
        checks++; if (a_lw !== 8'd4) begin errs++; $display("FAIL reset_lw: got %0d want 4", a_lw); end
        checks++; if (a_gc !== 8'd0) begin errs++; $display("FAIL reset_gc: got %0d want 0", a_gc); end
        checks++; if (wv_cnt != 1) begin errs++; $display("FAIL reset_wv_len: got %0d want 1", wv_cnt); end
        checks++; if (stat_a !== exp_a()) begin errs++; $display("FAIL reset_model_a: got %h want %h", stat_a, exp_a()); end
    endtask

    task automatic test_glitch();
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        pulse(1, 3); pulse(3, 3); pulse(1, 3);
        checks++; if (a_pc !== 8'd3) begin errs++; $display("FAIL glitch_pc: got %0d want 3", a_pc); end
        checks++; if (a_gc !== 8'd2) begin errs++; $display("FAIL glitch_gc: got %0d want 2", a_gc); end
        checks++; if (a_gf !== 1'b1) begin errs++; $display("FAIL glitch_flag: got %0d want 1", a_gf); end
        checks++; if (a_lw !== 8'd1) begin errs++; $display("FAIL glitch_lw: got %0d want 1", a_lw); end
        for (int i = 0; i < 20; i++) begin
            pulse($urandom_range(1, 6), $urandom_range(1, 4));
            checks++; if (stat_a !== exp_a()) begin errs++; $display("FAIL glitch_rand_a %0d: got %h want %h", i, stat_a, exp_a()); end
            checks++; if (stat_b !== exp_b()) begin errs++; $display("FAIL glitch_rand_b %0d: got %h want %h", i, stat_b, exp_b()); end
        end
    endtask

    task automatic test_saturation();
        int rise_at, rise_cnt;
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        rise_at = -1; rise_cnt = 0;
        for (int i = 0; i < 26; i++) begin
            cyc(i < 20, 1'b1, 1'b0);
            if (a_rise && rise_at < 0) rise_at = i;
            rise_cnt += a_rise;
            checks++; if (stat_b !== exp_b()) begin errs++; $display("FAIL sat_cyc_b %0d: got %h want %h", i, stat_b, exp_b()); end
        end
        checks++; if (rise_at != 1) begin errs++; $display("FAIL sat_rise_at: got %0d want 1", rise_at); end
        checks++; if (rise_cnt != 1) begin errs++; $display("FAIL sat_rise_len: got %0d want 1", rise_cnt); end
        checks++; if (b_lw !== 4'd15) begin errs++; $display("FAIL sat_lw_b: got %0d want 15", b_lw); end
        checks++; if (a_lw !== 8'd20) begin errs++; $display("FAIL sat_lw_a: got %0d want 20", a_lw); end
        checks++; if (b_gf !== 1'b0) begin errs++; $display("FAIL sat_gf_b: got %0d want 0", b_gf); end
    endtask

    task automatic test_count_sat();
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (5) pulse(3, 3);
        checks++; if (b_pc !== 2'd3) begin errs++; $display("FAIL cnt_sat_b: got %0d want 3", b_pc); end
        checks++; if (a_pc !== 8'd5) begin errs++; $display("FAIL cnt_sat_a: got %0d want 5", a_pc); end
        checks++; if (stat_b !== exp_b()) begin errs++; $display("FAIL cnt_sat_model_b: got %h want %h", stat_b, exp_b()); end
    endtask

    task automatic test_en_clear();
        cyc(1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        checks++; if (a_pc !== 8'd0) begin errs++; $display("FAIL en_drop_pc: got %0d want 0", a_pc); end
        pulse(3, 4);
        checks++; if (a_pc !== 8'd1) begin errs++; $display("FAIL en_good_pc: got %0d want 1", a_pc); end
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        checks++; if (a_wv !== 1'b0) begin errs++; $display("FAIL clr_fall_wv: got %0d want 0", a_wv); end
        checks++; if ({a_pc, a_gc, a_lw} !== 24'd0) begin errs++; $display("FAIL clr_fall_counts: got %h want 0", {a_pc, a_gc, a_lw}); end
        checks++; if (stat_a !== exp_a()) begin errs++; $display("FAIL clr_fall_model_a: got %h want %h", stat_a, exp_a()); end
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        pulse(2, 3);
        checks++; if (a_pc !== 8'd1) begin errs++; $display("FAIL clr_next_pc: got %0d want 1", a_pc); end
        checks++; if (a_lw !== 8'd2) begin errs++; $display("FAIL clr_next_lw: got %0d want 2", a_lw); end
    endtask

    task automatic test_async_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        checks++; if (stat_a !== exp_a()) begin errs++; $display("FAIL pre_rst_a: got %h want %h", stat_a, exp_a()); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (stat_a !== 32'd0) begin errs++; $display("FAIL async_rst_a: got %h want 0", stat_a); end
        checks++; if (stat_b !== 32'd0) begin errs++; $display("FAIL async_rst_b: got %h want 0", stat_b); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cyc(1'b1, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        checks++; if (a_pc !== 8'd0) begin errs++; $display("FAIL post_rst_pc: got %0d want 0", a_pc); end
        pulse(3, 4);
        checks++; if (stat_a !== exp_a()) begin errs++; $display("FAIL post_rst_model_a: got %h want %h", stat_a, exp_a()); end
        checks++; if (a_pc !== 8'd1) begin errs++; $display("FAIL post_rst_pulse: got %0d want 1", a_pc); end
    endtask

    task automatic test_random();
        bit s, e, cl;
        s = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0) s = ~s;
            e  = ($urandom_range(0, 24) != 0);
            cl = ($urandom_range(0, 59) == 0);
            cyc(s, e, cl);
            checks++; if (stat_a !== exp_a()) begin errs++; $display("FAIL rand_a %0d: got %h want %h", i, stat_a, exp_a()); end
            checks++; if (stat_b !== exp_b()) begin errs++; $display("FAIL rand_b %0d: got %h want %h", i, stat_b, exp_b()); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_saturation();
        test_count_sat();
        test_en_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
